// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port synchronous RAM between the
// instruction-fetch port and the load/store port. One access is granted per
// cycle, and the port that issued the one outstanding read gets its data back.
//
// Optional build macro: ARB_STARVE_GUARD_EN
//   When this macro is defined, a fetch starvation counter forces fetch to win
//   after STARVE_MAX consecutive denied cycles.
//   When it is undefined, data has strict priority over fetch.
//
// Owner register states:
//   state    | meaning
//   OWN_NONE | no read was issued last cycle
//   OWN_IF   | a fetch read was issued last cycle
//   OWN_D    | a load was issued last cycle
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [3:0]          d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                ram_en,
    output logic                ram_we,
    output logic [3:0]          ram_be,
    output logic [ADDR_W-3:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t r_owner;
    owner_t w_owner_nxt;
    logic   w_fetch_force;

    // The byte-offset bits are intentionally dropped (word-aligned RAM).
    logic   w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] r_starve_cnt;

    // Count consecutive denied fetch cycles, saturating; any fetch grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (if_req && (r_starve_cnt != 4'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_fetch_force = (r_starve_cnt == 4'(STARVE_MAX));
`else
    logic w_unused_cfg;
    assign w_unused_cfg  = (STARVE_MAX == 0);
    assign w_fetch_force = 1'b0;
`endif

    // Grant selection: data wins a tie unless the starvation guard forces fetch.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (d_req && !(if_req && w_fetch_force)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // RAM drive from whichever port holds the grant; idle drive is all zero.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        if (if_gnt) begin
            ram_en   = 1'b1;
            ram_addr = if_addr[ADDR_W-1:2];
        end else if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_be    = d_we ? d_be : 4'b0000;
            ram_addr  = d_addr[ADDR_W-1:2];
            ram_wdata = d_wdata;
        end
    end

    // Next owner: records who issued a read this cycle; stores leave no owner.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (if_gnt) begin
            w_owner_nxt = OWN_IF;
        end else if (d_gnt && !d_we) begin
            w_owner_nxt = OWN_D;
        end
    end

    // Owner register; clearing it on reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Response steering; masked during reset so no stale response leaks out.
    always_comb begin
        if_rvalid = !rst && (r_owner == OWN_IF);
        d_rvalid  = !rst && (r_owner == OWN_D);
        if_rdata  = if_rvalid ? ram_rdata : '0;
        d_rdata   = d_rvalid  ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed steps followed by randomized traffic, all checked
// against a transaction-level reference model (a shadow memory plus the
// pending response).
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int MEM_WORDS  = 2048;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-3:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM standing in for ram_0.
    logic [31:0] mem [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[10:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[10:0]];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    int          m_starve    = 0;
    int          m_pend      = 0;     // 0 none, 1 fetch, 2 load
    logic [31:0] m_pend_data = '0;
    bit          g_if, g_d;           // expected grants for the current cycle

    function automatic int widx(input logic [ADDR_W-1:0] a);
        return int'(a / 4) % MEM_WORDS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict the grants for the current inputs from the arbitration rules.
    task automatic predict();
        g_if = 1'b0;
        g_d  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                g_if = GUARD && (m_starve >= STARVE_MAX);
                g_d  = !g_if;
            end else begin
                g_if = if_req;
                g_d  = d_req;
            end
        end
    endtask

    // Compare every DUT output against the model, away from the rising edge.
    task automatic check_cycle();
        @(negedge clk);
        predict();
        if (rst) begin
            chk("rst_if_gnt",    {31'd0, if_gnt},    32'd0);
            chk("rst_d_gnt",     {31'd0, d_gnt},     32'd0);
            chk("rst_ram_en",    {31'd0, ram_en},    32'd0);
            chk("rst_ram_we",    {31'd0, ram_we},    32'd0);
            chk("rst_ram_be",    {28'd0, ram_be},    32'd0);
            chk("rst_ram_addr",  {2'd0, ram_addr},   32'd0);
            chk("rst_ram_wdata", ram_wdata,          32'd0);
            chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
            chk("rst_d_rvalid",  {31'd0, d_rvalid},  32'd0);
        end else begin
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, g_if});
            chk("d_gnt",  {31'd0, d_gnt},  {31'd0, g_d});
            chk("ram_en", {31'd0, ram_en}, {31'd0, g_if | g_d});
            if (g_if) begin
                chk("if_ram_addr", {2'd0, ram_addr}, if_addr >> 2);
                chk("if_ram_we",   {31'd0, ram_we},  32'd0);
                chk("if_ram_be",   {28'd0, ram_be},  32'd0);
            end else if (g_d) begin
                chk("d_ram_addr",  {2'd0, ram_addr}, d_addr >> 2);
                chk("d_ram_we",    {31'd0, ram_we},  {31'd0, d_we});
                chk("d_ram_be",    {28'd0, ram_be},  d_we ? {28'd0, d_be} : 32'd0);
                chk("d_ram_wdata", ram_wdata,        d_wdata);
            end
            chk("if_rvalid", {31'd0, if_rvalid}, (m_pend == 1) ? 32'd1 : 32'd0);
            chk("d_rvalid",  {31'd0, d_rvalid},  (m_pend == 2) ? 32'd1 : 32'd0);
            chk("if_rdata",  if_rdata, (m_pend == 1) ? m_pend_data : 32'd0);
            chk("d_rdata",   d_rdata,  (m_pend == 2) ? m_pend_data : 32'd0);
        end
    endtask

    // Clock edge: retire the access into the model, then release inputs.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_starve = 0;
            m_pend   = 0;
        end else begin
            m_pend = 0;
            if (g_if) begin
                m_pend      = 1;
                m_pend_data = ref_mem[widx(if_addr)];
                m_starve    = 0;
            end else if (g_d) begin
                if (d_we) begin
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) ref_mem[widx(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
                end else begin
                    m_pend      = 2;
                    m_pend_data = ref_mem[widx(d_addr)];
                end
            end
            if (if_req && !g_if && m_starve < STARVE_MAX) m_starve++;
        end
        #1;
    endtask

    task automatic tick();
        check_cycle();
        advance();
    endtask

    task automatic idle();
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'b0000;
        if_addr = '0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    int gnt_cnt;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = 32'h9E37_79B9 * i + 32'h1357_2468;
            ref_mem[i] = 32'h9E37_79B9 * i + 32'h1357_2468;
        end
        mem[1026] = 32'hDEAD_BEEF;  ref_mem[1026] = 32'hDEAD_BEEF;
        mem[8]    = 32'hFFFF_FFFF;  ref_mem[8]    = 32'hFFFF_FFFF;
        ram_rdata = '0;
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Fetch alone.
        if_req = 1'b1; if_addr = 32'h0000_1008;
        check_cycle();
        chk("fetch_gnt",  {31'd0, if_gnt}, 32'd1);
        chk("fetch_addr", {2'd0, ram_addr}, 32'd1026);
        advance();
        idle();
        check_cycle();
        chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        advance();

        // Contention: data wins, fetch granted once data drops.
        if_req = 1'b1; if_addr = 32'h0000_0040;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010;
        check_cycle();
        chk("cont_d_gnt", {31'd0, d_gnt}, 32'd1);
        advance();
        d_req = 1'b0;
        check_cycle();
        chk("cont_load_data", d_rdata, ref_mem[4]);
        chk("cont_if_gnt",    {31'd0, if_gnt}, 32'd1);
        advance();
        idle();
        tick();

        // Store with partial byte enables, then load the same word.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        tick();
        d_we = 1'b0; d_be = 4'b1111;
        check_cycle();
        chk("store_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        advance();
        idle();
        check_cycle();
        chk("store_load_data", d_rdata, 32'hFFFF_5678);
        advance();

        // Back-to-back fetches.
        for (int k = 0; k < 3; k++) begin
            if_req = 1'b1; if_addr = 32'(4 * k);
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) tick();

        // Reset while a fetch is in flight.
        if_req = 1'b1; if_addr = 32'h0000_0100;
        tick();
        idle();
        rst = 1'b1;
        check_cycle();
        chk("midrst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        advance();
        rst = 1'b0;
        check_cycle();
        chk("postrst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        advance();

        // Sustained contention from a clean counter.
        if_req = 1'b1; if_addr = 32'h0000_0080;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010;
        gnt_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            check_cycle();
            if (if_gnt === 1'b1) gnt_cnt++;
            advance();
        end
        chk("starve_if_gnt_count", 32'(gnt_cnt), GUARD ? 32'd1 : 32'd0);
        idle();
        tick();

        // Randomized traffic; requests hold while waiting for a grant.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!(if_req && !g_if)) begin
                if_req  = ($urandom_range(0, 9) < 7);
                if_addr = 32'($urandom_range(0, 32'h1FF));
            end
            if (!(d_req && !g_d)) begin
                d_req   = ($urandom_range(0, 9) < 6);
                d_we    = $urandom_range(0, 1) == 1;
                d_be    = 4'($urandom_range(0, 15));
                d_addr  = 32'($urandom_range(0, 32'h1FF));
                d_wdata = $urandom;
            end
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
